// File: rtl/mem_stage_pkg.sv
// Shared types for the LEGv8 MEM stage: memory FSM states and the
// control bundle carried through the EX/MEM register.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       valid;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       regWrite;
    logic       memtoReg;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack port. The pipeline stage is the master; the memory
// (or its model) is the slave and answers each request with a 1-cycle ack.
interface memory_stage_if #(parameter int N = 64);
  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_ack;
  logic [N-1:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata,
                  input  dm_ack, dm_rdata);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata,
                  output dm_ack, dm_rdata);
endinterface

// File: rtl/memory_stage_flopenr.sv
// Generic async-reset flop bank with load enable; builds the pipeline
// registers on both sides of MEM.
module flopenr #(parameter int W = 64) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  // Clear on reset, load when enabled, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   r_q <= '0;
    else if (en) r_q <= d;
  end

  assign q = r_q;
endmodule

// File: rtl/memory_stage.sv
// LEGv8 MEM stage: EX/MEM register, CBZ resolution, req/ack data-memory
// sequencing with pipeline stall, and the MEM/WB register.
module memory_stage
  import mem_stage_pkg::*;
#(parameter int N = 64) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_E,
  input  logic [N-1:0]  aluResult_E,
  input  logic [N-1:0]  writeData_E,
  input  logic [N-1:0]  PCBranch_E,
  input  logic          zero_E,
  input  logic          memRead_E,
  input  logic          memWrite_E,
  input  logic          branch_E,
  input  logic          regWrite_E,
  input  logic          memtoReg_E,
  input  logic [4:0]    rd_E,
  memory_stage_if.master dm,
  output logic          stall_M,
  output logic          PCSrc_M,
  output logic [N-1:0]  PCBranch_M,
  output logic          valid_W,
  output logic          regWrite_W,
  output logic          memtoReg_W,
  output logic [N-1:0]  readData_W,
  output logic [N-1:0]  aluResult_W,
  output logic [4:0]    rd_W
);
  localparam int CW  = $bits(ex_mem_ctrl_t);
  localparam int EXW = CW + 1 + 3*N;
  localparam int WBW = 8 + 2*N;

  ex_mem_ctrl_t   w_ctrl_E;
  ex_mem_ctrl_t   r_ctrl_M;
  logic           r_zero_M;
  logic [N-1:0]   r_alu_M, r_wdata_M, r_pcb_M;
  logic [EXW-1:0] w_exmem_d, w_exmem_q;
  logic [WBW-1:0] w_memwb_d, w_memwb_q;
  logic           w_en_M, w_mem_M, w_busy, w_ack;
  logic [N-1:0]   w_load_data;
  mem_state_t     r_state;

  assign w_ctrl_E = '{valid: valid_E, memRead: memRead_E, memWrite: memWrite_E,
                      branch: branch_E, regWrite: regWrite_E,
                      memtoReg: memtoReg_E, rd: rd_E};

  // EX/MEM: frozen while a memory op waits for its ack.
  assign w_en_M    = ~stall_M;
  assign w_exmem_d = {w_ctrl_E, zero_E, aluResult_E, writeData_E, PCBranch_E};

  flopenr #(.W(EXW)) u_exmem (
    .clk(clk), .reset(reset), .en(w_en_M), .d(w_exmem_d), .q(w_exmem_q)
  );

  assign {r_ctrl_M, r_zero_M, r_alu_M, r_wdata_M, r_pcb_M} = w_exmem_q;

  assign w_mem_M = r_ctrl_M.valid & (r_ctrl_M.memRead | r_ctrl_M.memWrite);
  assign w_busy  = (r_state == BUSY);
  // An ack only counts while a request is outstanding.
  assign w_ack   = w_busy & dm.dm_ack;

  // Request FSM: one IDLE cycle to see the op, then BUSY until ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_mem_M)   r_state <= BUSY;
        BUSY:    if (dm.dm_ack) r_state <= IDLE;
        default:                r_state <= IDLE;
      endcase
    end
  end

  // Bus outputs come only from registers, so they are glitch-free and
  // stable for the whole request.
  assign dm.dm_req   = w_busy;
  assign dm.dm_we    = w_busy & r_ctrl_M.memWrite;
  assign dm.dm_addr  = r_alu_M;
  assign dm.dm_wdata = r_wdata_M;

  assign stall_M    = w_mem_M & ~w_ack;
  assign PCSrc_M    = r_ctrl_M.valid & r_ctrl_M.branch & r_zero_M;
  assign PCBranch_M = r_pcb_M;

  // Load data is taken straight off the bus on the ack edge, which is the
  // same edge that releases the stall and writes MEM/WB.
  assign w_load_data = (r_ctrl_M.valid & r_ctrl_M.memRead) ? dm.dm_rdata : '0;

  // MEM/WB: a stalled cycle writes an all-zero bubble.
  assign w_memwb_d = stall_M ? '0 :
                     {r_ctrl_M.valid, r_ctrl_M.regWrite, r_ctrl_M.memtoReg,
                      r_ctrl_M.rd, w_load_data, r_alu_M};

  flopenr #(.W(WBW)) u_memwb (
    .clk(clk), .reset(reset), .en(1'b1), .d(w_memwb_d), .q(w_memwb_q)
  );

  assign {valid_W, regWrite_W, memtoReg_W, rd_W, readData_W, aluResult_W} = w_memwb_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: reset checks, a vector table for
// single-cycle ops, and a scoreboard-driven engine for memory sequences
// (hand-written and random).
module tb_memory_stage;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_E = 0, zero_E = 0, memRead_E = 0, memWrite_E = 0;
  logic         branch_E = 0, regWrite_E = 0, memtoReg_E = 0;
  logic [N-1:0] aluResult_E = '0, writeData_E = '0, PCBranch_E = '0;
  logic [4:0]   rd_E = '0;
  logic         stall_M, PCSrc_M, valid_W, regWrite_W, memtoReg_W;
  logic [N-1:0] PCBranch_M, readData_W, aluResult_W;
  logic [4:0]   rd_W;
  int           checks = 0, errors = 0;

  memory_stage_if #(.N(N)) dm();

  memory_stage #(.N(N)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .aluResult_E(aluResult_E),
    .writeData_E(writeData_E), .PCBranch_E(PCBranch_E), .zero_E(zero_E),
    .memRead_E(memRead_E), .memWrite_E(memWrite_E), .branch_E(branch_E),
    .regWrite_E(regWrite_E), .memtoReg_E(memtoReg_E), .rd_E(rd_E), .dm(dm),
    .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
    .valid_W(valid_W), .regWrite_W(regWrite_W), .memtoReg_W(memtoReg_W),
    .readData_W(readData_W), .aluResult_W(aluResult_W), .rd_W(rd_W)
  );

  always #5 clk = ~clk;

  // kind: 0 ALU op, 1 LDUR, 2 STUR, 3 CBZ. lat = request cycles up to and
  // including the ack cycle. spur = pulse ack while no request is out.
  typedef struct {
    bit v; int kind; logic [N-1:0] alu, wd, pcb; bit z; logic [4:0] rd;
    int lat; bit spur;
  } instr_t;

  typedef struct {
    bit v; int kind; logic [N-1:0] alu, pcb; bit z; logic [4:0] rd;
    bit e_pcsrc, e_vw, e_rw, e_mtr;
  } vec_t;

  instr_t prog[$];
  vec_t   tbl[6];

  function automatic instr_t mk(bit v, int kind, logic [N-1:0] alu, logic [N-1:0] wd,
                                logic [N-1:0] pcb, bit z, logic [4:0] rd, int lat, bit spur);
    instr_t i;
    i.v = v; i.kind = kind; i.alu = alu; i.wd = wd; i.pcb = pcb;
    i.z = z; i.rd = rd; i.lat = lat; i.spur = spur;
    return i;
  endfunction

  function automatic instr_t bubble();
    return mk(1'b0, 0, '0, '0, '0, 1'b0, 5'd0, 1, 1'b0);
  endfunction

  function automatic instr_t next_instr();
    if (prog.size() == 0) return bubble();
    return prog.pop_front();
  endfunction

  function automatic bit is_mem(instr_t i);
    return i.v && (i.kind == 1 || i.kind == 2);
  endfunction

  // Contents the memory returns for any address.
  function automatic logic [N-1:0] memfn(logic [N-1:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic drive(instr_t i);
    valid_E    = i.v;
    memRead_E  = (i.kind == 1);
    memWrite_E = (i.kind == 2);
    branch_E   = (i.kind == 3);
    regWrite_E = (i.kind <= 1);
    memtoReg_E = (i.kind == 1);
    aluResult_E = i.alu; writeData_E = i.wd; PCBranch_E = i.pcb;
    zero_E = i.z; rd_E = i.rd;
  endtask

  // Runs the queued program through an empty pipe. Model: each instruction
  // sits in M for 1 cycle, or lat+1 cycles for a valid memory op; when it
  // leaves, WB shows its controls, otherwise WB shows a bubble.
  // Must be entered just after a posedge with a bubble in M.
  task automatic run_prog(int max_cyc);
    instr_t cm, ce;
    int occ = 0, reqc = 0, cyc = 0;
    bit st, wchk = 0, ev = 0, erw = 0, emtr = 0;
    logic [4:0] erd = '0;
    logic [N-1:0] ealu = '0, edat = '0;
    cm = bubble();
    ce = next_instr(); drive(ce);
    forever begin
      @(negedge clk);
      dm.dm_ack = 1'b0;
      if (dm.dm_req) begin
        reqc++;
        chk("dm_addr", dm.dm_addr, cm.alu);
        chk1("dm_we", dm.dm_we, cm.kind == 2);
        if (cm.kind == 2) chk("dm_wdata", dm.dm_wdata, cm.wd);
        if (reqc == cm.lat) begin
          dm.dm_ack = 1'b1; dm.dm_rdata = memfn(cm.alu);
        end
      end else begin
        reqc = 0;
        if (cm.spur) begin
          dm.dm_ack = 1'b1; dm.dm_rdata = {$urandom, $urandom};
        end
      end
      #1;
      if (wchk) begin
        chk1("valid_W", valid_W, ev);
        chk1("regWrite_W", regWrite_W, erw);
        if (ev) begin
          chk1("memtoReg_W", memtoReg_W, emtr);
          chk("rd_W", 64'(rd_W), 64'(erd));
          chk("aluResult_W", aluResult_W, ealu);
          chk("readData_W", readData_W, edat);
        end
      end
      chk1("PCSrc_M", PCSrc_M, cm.v && cm.kind == 3 && cm.z);
      if (cm.v && cm.kind == 3 && cm.z) chk("PCBranch_M", PCBranch_M, cm.pcb);
      st = stall_M;
      if (prog.size() == 0 && !cm.v && !ce.v) break;
      @(posedge clk); #1;
      occ++;
      if (!st) begin
        chk("occupancy", 64'(occ), 64'(is_mem(cm) ? cm.lat + 1 : 1));
        ev = cm.v; erw = (cm.kind <= 1); emtr = (cm.kind == 1);
        erd = cm.rd; ealu = cm.alu;
        edat = (cm.v && cm.kind == 1) ? memfn(cm.alu) : '0;
        occ = 0; cm = ce; ce = next_instr(); drive(ce);
      end else begin
        ev = 0; erw = 0;
      end
      wchk = 1;
      cyc++;
      if (cyc >= max_cyc) begin
        checks++; errors++;
        $display("FAIL run_prog timeout: %0d cycles, %0d instrs left", cyc, prog.size());
        break;
      end
    end
    dm.dm_ack = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 0, 64'h2A, 64'h0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 3, 64'h0, 64'h40, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 3, 64'h0, 64'h40, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 3, 64'h0, 64'h40, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 0, 64'h55, 64'h0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0};

    dm.dm_ack = 1'b0; dm.dm_rdata = '0;
    drive(bubble());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst dm_req", dm.dm_req, 1'b0);
    chk1("rst stall_M", stall_M, 1'b0);
    chk1("rst PCSrc_M", PCSrc_M, 1'b0);
    chk("rst PCBranch_M", PCBranch_M, '0);
    chk1("rst valid_W", valid_W, 1'b0);
    chk1("rst regWrite_W", regWrite_W, 1'b0);
    chk("rst aluResult_W", aluResult_W, '0);
    chk("rst readData_W", readData_W, '0);
    chk("rst rd_W", 64'(rd_W), 64'd0);
    reset = 1'b0;

    // Reset in the middle of an outstanding load.
    @(posedge clk); #1;
    drive(mk(1'b1, 1, 64'h100, '0, '0, 1'b0, 5'd2, 3, 1'b0));
    @(posedge clk); #1;
    drive(bubble());
    begin
      int k = 0;
      while (!dm.dm_req && k < 5) begin @(negedge clk); k++; end
    end
    chk1("pre-reset dm_req", dm.dm_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("midrst dm_req", dm.dm_req, 1'b0);
    chk1("midrst stall_M", stall_M, 1'b0);
    chk1("midrst valid_W", valid_W, 1'b0);
    chk("midrst dm_addr", dm.dm_addr, '0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); dm.dm_ack = 1'b1; dm.dm_rdata = 64'h1234;
    @(negedge clk);
    chk1("late ack valid_W", valid_W, 1'b0);
    chk1("late ack dm_req", dm.dm_req, 1'b0);
    chk1("late ack stall_M", stall_M, 1'b0);
    dm.dm_ack = 1'b0;

    // Single-cycle ops from the vector table.
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(mk(tbl[i].v, tbl[i].kind, tbl[i].alu, '0, tbl[i].pcb, tbl[i].z, tbl[i].rd, 1, 1'b0));
      @(posedge clk); #1;
      drive(bubble());
      @(negedge clk);
      chk1($sformatf("vec%0d PCSrc_M", i), PCSrc_M, tbl[i].e_pcsrc);
      chk1($sformatf("vec%0d stall_M", i), stall_M, 1'b0);
      if (tbl[i].e_pcsrc) chk($sformatf("vec%0d PCBranch_M", i), PCBranch_M, tbl[i].pcb);
      @(negedge clk);
      chk1($sformatf("vec%0d PCSrc_M after", i), PCSrc_M, 1'b0);
      chk1($sformatf("vec%0d valid_W", i), valid_W, tbl[i].e_vw);
      chk1($sformatf("vec%0d regWrite_W", i), regWrite_W, tbl[i].e_rw);
      chk1($sformatf("vec%0d memtoReg_W", i), memtoReg_W, tbl[i].e_mtr);
      chk($sformatf("vec%0d aluResult_W", i), aluResult_W, tbl[i].alu);
      chk($sformatf("vec%0d rd_W", i), 64'(rd_W), 64'(tbl[i].rd));
      chk($sformatf("vec%0d readData_W", i), readData_W, '0);
    end

    // LDUR with ack in the third request cycle.
    @(posedge clk); #1;
    prog.push_back(mk(1'b1, 1, 64'h100, '0, '0, 1'b0, 5'd9, 3, 1'b0));
    run_prog(100);
    // STUR acked in the first request cycle.
    @(posedge clk); #1;
    prog.push_back(mk(1'b1, 2, 64'h80, 64'hDEAD, '0, 1'b0, 5'd0, 1, 1'b0));
    run_prog(100);
    // Back-to-back loads with spurious acks while IDLE.
    @(posedge clk); #1;
    prog.push_back(mk(1'b1, 1, 64'h200, '0, '0, 1'b0, 5'd4, 2, 1'b1));
    prog.push_back(mk(1'b1, 1, 64'h208, '0, '0, 1'b0, 5'd5, 1, 1'b1));
    run_prog(100);

    // Random instruction stream.
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++)
      prog.push_back(mk($urandom_range(0, 4) != 0, int'($urandom_range(0, 3)),
                        {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        int'($urandom_range(1, 4)), $urandom_range(0, 2) == 0));
    run_prog(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
